// File: rtl/memory_controller_pkg.sv
// Shared definitions for the memory controller slice.
//   state_t  : controller FSM states (IDLE -> ACCESS -> RESPOND -> IDLE)
//   grant_t  : which L1 owns the current transaction
//   IO_BASE_DEFAULT : first uncacheable (MMIO) byte address
package memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/memory_controller_if.sv
// Bus interfaces around the memory controller.
//   mem_l1_if  : instruction-side and data-side L1 miss/write paths.
//                master = the L1 caches, slave = the controller.
//   mem_ram_if : single-ported backing RAM.
//                master = the controller, slave = the RAM model.
//
// Handshake: *_request is a level held by the L1 until it sees the
// matching one-cycle *_ready pulse; address/write/data must stay stable
// while the request is high. The L1 drops the request by the cycle after
// ready; a request still high while the controller is idle starts a new
// transaction. *_read_data is valid from the ready pulse until the next
// read completes.
interface mem_l1_if;
    logic        i_request;
    logic [31:0] i_address;
    logic [31:0] i_read_data;
    logic        i_ready;
    logic        i_should_cache;

    logic        d_request;
    logic [31:0] d_address;
    logic        d_write;
    logic [31:0] d_write_data;
    logic [31:0] d_read_data;
    logic        d_ready;
    logic        d_should_cache;

    modport master (
        output i_request, i_address,
        input  i_read_data, i_ready, i_should_cache,
        output d_request, d_address, d_write, d_write_data,
        input  d_read_data, d_ready, d_should_cache
    );

    modport slave (
        input  i_request, i_address,
        output i_read_data, i_ready, i_should_cache,
        input  d_request, d_address, d_write, d_write_data,
        output d_read_data, d_ready, d_should_cache
    );
endinterface

interface mem_ram_if;
    logic [31:0] ram_address;
    logic [31:0] ram_write_data;
    logic        ram_read_enable;
    logic        ram_write_enable;
    logic [31:0] ram_read_data;

    modport master (
        output ram_address, ram_write_data, ram_read_enable, ram_write_enable,
        input  ram_read_data
    );

    modport slave (
        input  ram_address, ram_write_data, ram_read_enable, ram_write_enable,
        output ram_read_data
    );
endinterface

// File: rtl/memory_controller_arbiter.sv
// Two-way round-robin arbiter.
// Ports:
//   clock_i   : clock
//   reset_i   : synchronous active-high reset (last grant -> DATA, so the
//               instruction side wins the first tie)
//   req_i     : [0] instruction request, [1] data request
//   advance_i : a grant is being taken this cycle; remember who got it
//   grant_o   : one-hot grant, combinational from req_i and last grant
module rr_arbiter2
    import memory_pkg::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    grant_t last_grant_q;
    grant_t last_grant_d;

    always_comb begin
        grant_o      = req_i;
        last_grant_d = last_grant_q;
        // On a tie the side that did not win last time takes the grant.
        if (req_i == 2'b11) begin
            grant_o = (last_grant_q == GRANT_DATA) ? 2'b01 : 2'b10;
        end
        if (advance_i && grant_o[1]) begin
            last_grant_d = GRANT_DATA;
        end else if (advance_i && grant_o[0]) begin
            last_grant_d = GRANT_INSTR;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            last_grant_q <= GRANT_DATA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/memory_controller.sv
// Memory controller: shares one single-ported RAM between the instruction
// and data L1s. Round-robin arbitration, fixed-latency RAM sequencing and a
// one-cycle ready pulse per transaction.
// Parameters:
//   MEM_LATENCY : RAM access cycles per transaction (>= 1)
//   IO_BASE     : addresses >= IO_BASE are uncacheable
// Ports:
//   clock       : single clock, all state on posedge
//   reset       : synchronous, active-high
//   l1          : mem_l1_if.slave  - both L1 request/response paths
//   ram         : mem_ram_if.master - backing RAM
//   dbg_state_o : current FSM state, for observation only
module memory_controller
    import memory_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 3,
    parameter logic [31:0] IO_BASE     = IO_BASE_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    mem_l1_if.slave    l1,
    mem_ram_if.master  ram,
    output state_t     dbg_state_o
);

    // Counter reloads only in IDLE, so it never needs to hold more than
    // MEM_LATENCY-1.
    localparam int unsigned   CW         = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(MEM_LATENCY - 1);

    state_t        state_q;
    logic [CW-1:0] count_q;
    grant_t        grant_q;
    logic          is_write_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          i_ready_q;
    logic          d_ready_q;
    logic          read_en_q;
    logic          write_en_q;

    logic [1:0]    arb_grant;
    logic          arb_advance;

    assign arb_advance = (state_q == ST_IDLE);

    rr_arbiter2 u_arb (
        .clock_i   (clock),
        .reset_i   (reset),
        .req_i     ({l1.d_request, l1.i_request}),
        .advance_i (arb_advance),
        .grant_o   (arb_grant)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            grant_q    <= GRANT_INSTR;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            i_ready_q  <= 1'b0;
            d_ready_q  <= 1'b0;
            read_en_q  <= 1'b0;
            write_en_q <= 1'b0;
        end else begin
            i_ready_q  <= 1'b0;
            d_ready_q  <= 1'b0;
            write_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_grant != 2'b00) begin
                        state_q <= ST_ACCESS;
                        count_q <= COUNT_INIT;
                        wdata_q <= l1.d_write_data;
                        if (arb_grant[1]) begin
                            grant_q    <= GRANT_DATA;
                            addr_q     <= l1.d_address;
                            is_write_q <= l1.d_write;
                            read_en_q  <= ~l1.d_write;
                            // With a one-cycle access the only ACCESS
                            // cycle is also the write cycle.
                            write_en_q <= l1.d_write && (COUNT_INIT == '0);
                        end else begin
                            grant_q    <= GRANT_INSTR;
                            addr_q     <= l1.i_address;
                            is_write_q <= 1'b0;
                            read_en_q  <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (count_q == '0) begin
                        if (!is_write_q) begin
                            rdata_q <= ram.ram_read_data;
                        end
                        read_en_q <= 1'b0;
                        i_ready_q <= (grant_q == GRANT_INSTR);
                        d_ready_q <= (grant_q == GRANT_DATA);
                        state_q   <= ST_RESPOND;
                    end else begin
                        count_q    <= count_q - CW'(1);
                        // Write strobe lands on the final ACCESS cycle, so
                        // a reset before then aborts the write entirely.
                        write_en_q <= is_write_q && (count_q == CW'(1));
                    end
                end
                ST_RESPOND: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are forced low while reset is held, even before the first
    // reset edge clears the registers.
    assign ram.ram_address      = addr_q;
    assign ram.ram_write_data   = wdata_q;
    assign ram.ram_read_enable  = read_en_q & ~reset;
    assign ram.ram_write_enable = write_en_q & ~reset;

    assign l1.i_ready     = i_ready_q & ~reset;
    assign l1.d_ready     = d_ready_q & ~reset;
    assign l1.i_read_data = rdata_q;
    assign l1.d_read_data = rdata_q;

    assign l1.i_should_cache = (l1.i_address < IO_BASE);
    assign l1.d_should_cache = (l1.d_address < IO_BASE);

    assign dbg_state_o = state_q;

endmodule
